// File: rtl/jtag_pkg.sv
// Shared TAP definitions: IEEE 1149.1 state encoding, IR capture pattern and the TAP next-state function.
package jtag_pkg;

  typedef enum logic [3:0] {
    TAP_EX2DR   = 4'h0,
    TAP_EX1DR   = 4'h1,
    TAP_SHDR    = 4'h2,
    TAP_PAUSEDR = 4'h3,
    TAP_SELIR   = 4'h4,
    TAP_UPDDR   = 4'h5,
    TAP_CAPDR   = 4'h6,
    TAP_SELDR   = 4'h7,
    TAP_EX2IR   = 4'h8,
    TAP_EX1IR   = 4'h9,
    TAP_SHIR    = 4'hA,
    TAP_PAUSEIR = 4'hB,
    TAP_RTI     = 4'hC,
    TAP_UPDIR   = 4'hD,
    TAP_CAPIR   = 4'hE,
    TAP_TLR     = 4'hF
  } tap_state_t;

  localparam logic [1:0] IR_CAPTURE_PATTERN = 2'b01;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TAP_TLR;
    case (s)
      TAP_TLR:     n = tms ? TAP_TLR   : TAP_RTI;
      TAP_RTI:     n = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELDR:   n = tms ? TAP_SELIR : TAP_CAPDR;
      TAP_CAPDR:   n = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_SHDR:    n = tms ? TAP_EX1DR : TAP_SHDR;
      TAP_EX1DR:   n = tms ? TAP_UPDDR : TAP_PAUSEDR;
      TAP_PAUSEDR: n = tms ? TAP_EX2DR : TAP_PAUSEDR;
      TAP_EX2DR:   n = tms ? TAP_UPDDR : TAP_SHDR;
      TAP_UPDDR:   n = tms ? TAP_SELDR : TAP_RTI;
      TAP_SELIR:   n = tms ? TAP_TLR   : TAP_CAPIR;
      TAP_CAPIR:   n = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_SHIR:    n = tms ? TAP_EX1IR : TAP_SHIR;
      TAP_EX1IR:   n = tms ? TAP_UPDIR : TAP_PAUSEIR;
      TAP_PAUSEIR: n = tms ? TAP_EX2IR : TAP_PAUSEIR;
      TAP_EX2IR:   n = tms ? TAP_UPDIR : TAP_SHIR;
      TAP_UPDIR:   n = tms ? TAP_SELDR : TAP_RTI;
      default:     n = TAP_TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_edge_sync.sv
// Three-flop synchronizer for an asynchronous clock-like pin; emits one-cycle rise/fall pulses.
// Latency: pin edge to pulse 2 cycles. No backpressure.
module jtag_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [2:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 3'b000;
    end else begin
      r_sync <= {r_sync[1:0], i_async};
    end
  end

  // r_sync[0] is the metastability stage; edges are judged on the two settled stages.
  assign o_rise = r_sync[1] & ~r_sync[2];
  assign o_fall = ~r_sync[1] & r_sync[2];

endmodule

// File: rtl/jtag_tap_sync.sv
// JTAG TAP oversampled in io_clk: 1149.1 FSM, IR, BYPASS/IDCODE/USER DRs and user capture/update handshake.
// Define JTAG_TRST_EN to add the io_jtag_trst_n pin that holds the TAP in Test-Logic-Reset.
module jtag_tap_sync
  import jtag_pkg::*;
#(
  parameter int               IR_W      = 4,
  parameter logic [31:0]      IDCODE    = 32'h10001FFF,
  parameter logic [IR_W-1:0]  IR_IDCODE = IR_W'(4'h1),
  parameter logic [IR_W-1:0]  IR_USER   = IR_W'(4'h8),
  parameter int               USER_DR_W = 32
) (
  input  logic                 io_clk,
  input  logic                 io_reset_n,
`ifdef JTAG_TRST_EN
  input  logic                 io_jtag_trst_n,
`endif
  input  logic                 io_jtag_tck,
  input  logic                 io_jtag_tms,
  input  logic                 io_jtag_tdi,
  output logic                 io_jtag_tdo,
  input  logic [USER_DR_W-1:0] io_user_capture_data,
  output logic                 io_user_capture_req,
  output logic                 io_user_update_valid,
  output logic [USER_DR_W-1:0] io_user_update_data,
  output logic [3:0]           io_tap_state
);

  logic                 w_tck_rise;
  logic                 w_tck_fall;
  logic [1:0]           r_tms_sync;
  logic [1:0]           r_tdi_sync;
  logic                 w_tms;
  logic                 w_tdi;
  logic                 w_trst;
  tap_state_t           r_state;
  tap_state_t           w_state_nxt;
  logic [IR_W-1:0]      r_ir;
  logic [IR_W-1:0]      r_ir_sr;
  logic [31:0]          r_idcode_sr;
  logic [USER_DR_W-1:0] r_user_sr;
  logic                 r_bypass;
  logic                 r_tdo;
  logic                 r_cap_req;
  logic                 r_upd_vld;
  logic [USER_DR_W-1:0] r_upd_dat;
  logic                 w_sel_idcode;
  logic                 w_sel_user;
  logic                 w_step;

  jtag_edge_sync u_tck_sync (
    .i_clk   (io_clk),
    .i_rst_n (io_reset_n),
    .i_async (io_jtag_tck),
    .o_rise  (w_tck_rise),
    .o_fall  (w_tck_fall)
  );

  always_ff @(posedge io_clk or negedge io_reset_n) begin
    if (!io_reset_n) begin
      r_tms_sync <= 2'b00;
      r_tdi_sync <= 2'b00;
    end else begin
      r_tms_sync <= {r_tms_sync[0], io_jtag_tms};
      r_tdi_sync <= {r_tdi_sync[0], io_jtag_tdi};
    end
  end

  assign w_tms = r_tms_sync[1];
  assign w_tdi = r_tdi_sync[1];

`ifdef JTAG_TRST_EN
  logic [1:0] r_trst_sync;

  // Resets into the asserted level so the TAP stays parked until TRST is seen released.
  always_ff @(posedge io_clk or negedge io_reset_n) begin
    if (!io_reset_n) begin
      r_trst_sync <= 2'b00;
    end else begin
      r_trst_sync <= {r_trst_sync[0], io_jtag_trst_n};
    end
  end

  assign w_trst = ~r_trst_sync[1];
`else
  assign w_trst = 1'b0;
`endif

  assign w_state_nxt  = tap_next(r_state, w_tms);
  assign w_sel_idcode = (r_ir == IR_IDCODE);
  assign w_sel_user   = (r_ir == IR_USER);
  assign w_step       = w_tck_rise & ~w_trst;

  always_ff @(posedge io_clk or negedge io_reset_n) begin
    if (!io_reset_n) begin
      r_state <= TAP_TLR;
    end else if (w_trst) begin
      r_state <= TAP_TLR;
    end else if (w_tck_rise) begin
      r_state <= w_state_nxt;
    end
  end

  // TLR entry takes priority: it can only coincide with leaving TLR/SelIR, never Update-IR.
  always_ff @(posedge io_clk or negedge io_reset_n) begin
    if (!io_reset_n) begin
      r_ir    <= IR_IDCODE;
      r_ir_sr <= '0;
    end else if (w_trst) begin
      r_ir    <= IR_IDCODE;
    end else if (w_tck_rise) begin
      if (r_state == TAP_CAPIR) begin
        r_ir_sr <= IR_W'(IR_CAPTURE_PATTERN);
      end else if (r_state == TAP_SHIR) begin
        r_ir_sr <= {w_tdi, r_ir_sr[IR_W-1:1]};
      end
      if (w_state_nxt == TAP_TLR) begin
        r_ir <= IR_IDCODE;
      end else if (r_state == TAP_UPDIR) begin
        r_ir <= r_ir_sr;
      end
    end
  end

  always_ff @(posedge io_clk or negedge io_reset_n) begin
    if (!io_reset_n) begin
      r_idcode_sr <= '0;
      r_user_sr   <= '0;
      r_bypass    <= 1'b0;
    end else if (w_step) begin
      if (r_state == TAP_CAPDR) begin
        if (w_sel_idcode) begin
          r_idcode_sr <= IDCODE;
        end else if (w_sel_user) begin
          r_user_sr <= io_user_capture_data;
        end else begin
          r_bypass <= 1'b0;
        end
      end else if (r_state == TAP_SHDR) begin
        if (w_sel_idcode) begin
          r_idcode_sr <= {w_tdi, r_idcode_sr[31:1]};
        end else if (w_sel_user) begin
          r_user_sr <= {w_tdi, r_user_sr[USER_DR_W-1:1]};
        end else begin
          r_bypass <= w_tdi;
        end
      end
    end
  end

  always_ff @(posedge io_clk or negedge io_reset_n) begin
    if (!io_reset_n) begin
      r_cap_req <= 1'b0;
      r_upd_vld <= 1'b0;
      r_upd_dat <= '0;
    end else begin
      r_cap_req <= w_step & (r_state == TAP_CAPDR) & w_sel_user;
      r_upd_vld <= w_step & (r_state == TAP_UPDDR) & w_sel_user;
      if (w_step && (r_state == TAP_UPDDR) && w_sel_user) begin
        r_upd_dat <= r_user_sr;
      end
    end
  end

  // TDO changes only on the falling TCK edge so the external sampler sees it stable at the next rise.
  always_ff @(posedge io_clk or negedge io_reset_n) begin
    if (!io_reset_n) begin
      r_tdo <= 1'b0;
    end else if (w_trst) begin
      r_tdo <= 1'b0;
    end else if (w_tck_fall) begin
      if (r_state == TAP_SHIR) begin
        r_tdo <= r_ir_sr[0];
      end else if (r_state == TAP_SHDR) begin
        if (w_sel_idcode) begin
          r_tdo <= r_idcode_sr[0];
        end else if (w_sel_user) begin
          r_tdo <= r_user_sr[0];
        end else begin
          r_tdo <= r_bypass;
        end
      end else begin
        r_tdo <= 1'b0;
      end
    end
  end

  assign io_jtag_tdo          = r_tdo;
  assign io_user_capture_req  = r_cap_req;
  assign io_user_update_valid = r_upd_vld;
  assign io_user_update_data  = r_upd_dat;
  assign io_tap_state         = r_state;

endmodule
